// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: ALU opcodes, FSM state
// encodings and the carry-in rule for subtract-style operations.
package alu_pkg;

  // ALUOp encodings understood by the registered ALU
  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  // Issuer sequence: one command walks IDLE -> ISSUE -> CAPTURE -> WB -> IDLE
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WB      = 2'd3
  } state_t;

  // SUB and SLT are computed by the ALU as R2 + ~R3 + 1, so they need c_in set
  function automatic logic op_carry_in(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Operand register file for the ALU command issuer.
// One synchronous write port (shared by direct loads and write-back),
// two asynchronous read ports, whole array cleared by synchronous reset.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int N    = 32,
  parameter int REGS = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [N-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [N-1:0]  rdata_b
);

  logic [N-1:0] regs_reg [REGS];

  // Single write port; reset clears every entry so a fresh run reads zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we) begin
      regs_reg[waddr] <= wdata;
    end
  end

  // Asynchronous reads: the issuer samples operands in the accepting cycle
  always_comb begin
    rdata_a = regs_reg[raddr_a];
    rdata_b = regs_reg[raddr_b];
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command-side master for a 1-cycle registered ALU.
// Accepts one command per handshake, fetches operands from the internal
// register file, drives the ALU, and writes the captured result back.
// A command accepted at edge k produces a done pulse visible after edge k+3;
// the next command can be accepted at edge k+4.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int N    = 32,
  parameter int REGS = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  // command channel
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  input  logic [AW-1:0] cmd_rt,
  // direct register load (only honoured while idle)
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data,
  // ALU drive / capture
  output logic [N-1:0]  alu_R2,
  output logic [N-1:0]  alu_R3,
  output logic [2:0]    alu_ALUOp,
  output logic          alu_c_in,
  input  logic [N-1:0]  alu_R1,
  input  logic          alu_c_out,
  // completion report
  output logic          done,
  output logic [AW-1:0] done_rd,
  output logic [N-1:0]  done_result,
  output logic          done_carry,
  output logic          carry_flag
);

  state_t        state_reg;
  logic [AW-1:0] rd_reg;

  logic [N-1:0]  alu_r2_reg;
  logic [N-1:0]  alu_r3_reg;
  logic [2:0]    alu_op_reg;
  logic          alu_c_in_reg;

  logic          done_reg;
  logic [AW-1:0] done_rd_reg;
  logic [N-1:0]  done_result_reg;
  logic          done_carry_reg;
  logic          carry_flag_reg;

  logic [N-1:0]  rf_rdata_a;
  logic [N-1:0]  rf_rdata_b;
  logic [N-1:0]  operand_a;
  logic [N-1:0]  operand_b;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [N-1:0]  rf_wdata;

  logic          cmd_accept;

  assign cmd_ready  = (state_reg == ST_IDLE);
  assign cmd_accept = cmd_valid && cmd_ready;

  // Write port arbitration: write-back owns the port in WB, loads only in IDLE
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if (state_reg == ST_WB) begin
      rf_we    = 1'b1;
      rf_waddr = rd_reg;
      rf_wdata = alu_R1;
    end else if ((state_reg == ST_IDLE) && ld_valid) begin
      rf_we    = 1'b1;
    end
  end

  alu_regfile #(
    .N    (N),
    .REGS (REGS),
    .AW   (AW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (cmd_rs),
    .rdata_a (rf_rdata_a),
    .raddr_b (cmd_rt),
    .rdata_b (rf_rdata_b)
  );

  // Operand fetch with load bypass: a load landing in the accepting cycle is
  // forwarded, so the command sees the freshly loaded value (load-then-read)
  always_comb begin
    operand_a = rf_rdata_a;
    operand_b = rf_rdata_b;
    if (ld_valid && (ld_addr == cmd_rs)) begin
      operand_a = ld_data;
    end
    if (ld_valid && (ld_addr == cmd_rt)) begin
      operand_b = ld_data;
    end
  end

  // Issuer FSM with registered ALU drive and completion outputs.
  // ALU inputs are loaded on acceptance so they are valid throughout ISSUE
  // and held unchanged through CAPTURE and WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      rd_reg          <= '0;
      alu_r2_reg      <= '0;
      alu_r3_reg      <= '0;
      alu_op_reg      <= '0;
      alu_c_in_reg    <= 1'b0;
      done_reg        <= 1'b0;
      done_rd_reg     <= '0;
      done_result_reg <= '0;
      done_carry_reg  <= 1'b0;
      carry_flag_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_accept) begin
            state_reg    <= ST_ISSUE;
            rd_reg       <= cmd_rd;
            alu_r2_reg   <= operand_a;
            alu_r3_reg   <= operand_b;
            alu_op_reg   <= cmd_op;
            alu_c_in_reg <= op_carry_in(cmd_op);
          end
        end
        ST_ISSUE: begin
          state_reg <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state_reg <= ST_WB;
        end
        ST_WB: begin
          // alu_R1/alu_c_out are stable here; the register write happens on
          // the same edge through the write port above
          state_reg       <= ST_IDLE;
          done_reg        <= 1'b1;
          done_rd_reg     <= rd_reg;
          done_result_reg <= alu_R1;
          done_carry_reg  <= alu_c_out;
          carry_flag_reg  <= alu_c_out;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_R2      = alu_r2_reg;
  assign alu_R3      = alu_r3_reg;
  assign alu_ALUOp   = alu_op_reg;
  assign alu_c_in    = alu_c_in_reg;
  assign done        = done_reg;
  assign done_rd     = done_rd_reg;
  assign done_result = done_result_reg;
  assign done_carry  = done_carry_reg;
  assign carry_flag  = carry_flag_reg;

endmodule
